cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Producer end of the common data bus (CDB) that reservation stations and the ROB snoop.
- Collects completed results from NUM_FU functional units, buffers each FU's results in a small per-FU FIFO, and picks one per cycle round-robin.
- Drives the registered CDB broadcast (rob_ix, value, dest, valid).
- Applies per-FU backpressure so no functional unit ever loses a result.

Parameters:
- NUM_FU, 4, number of functional-unit result ports (≥2).
- BUF_DEPTH, 2, entries per per-FU result FIFO (≥1).
- ROB_IX_W, 3, ROB index width (ROB size 8).

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  asynchronous, active-high reset.
- fu_valid_in  input  NUM_FU  FU i has a result this cycle.
- fu_rob_ix_in  input  NUM_FU*ROB_IX_W  packed ROB indices, FU i at slice i.
- fu_value_in  input  NUM_FU*32  packed signed result values.
- fu_dest_in  input  NUM_FU*32  packed destination fields.
- fu_ready_out  output  NUM_FU  FU i's buffer can accept a result.
- cdb_valid_out  output  1  CDB broadcast valid.
- cdb_rob_ix_out  output  ROB_IX_W  broadcast ROB index.
- cdb_value_out  output  32  broadcast value (signed).
- cdb_dest_out  output  32  broadcast destination.
- flush_in  input  1  exists only with CDB_FLUSH_EN.

Behaviour:
- Reset (async, any cycle, including mid-operation): all FIFOs empty, rr_ptr=0, cdb_valid_out=0, cdb_rob_ix_out=0, cdb_value_out=0, cdb_dest_out=0, fu_ready_out=all 1s once reset is released.
- Handshake: a result is accepted at a rising edge where fu_valid_in[i] && fu_ready_out[i]. fu_valid_in while not ready is ignored; the FU must hold the result.
- fu_ready_out[i] = (count[i] != BUF_DEPTH), driven only from registered count, with no combinational path from the CDB grant. A full FIFO deasserts ready even if it is popped that same cycle.
- Push and pop on the same FIFO in the same cycle: count unchanged, order preserved.
- Arbitration is combinational over FIFO heads as they stand at the start of the cycle:
  - winner = first non-empty FIFO scanning rr_ptr, rr_ptr+1, ... modulo NUM_FU;
  - at the edge, the winner's head is popped and registered onto the cdb_*_out ports with cdb_valid_out=1;
  - rr_ptr <= (winner+1) mod NUM_FU.
- All FIFOs empty: cdb_valid_out<=0, rr_ptr unchanged, and data outputs hold their last values (only meaningful while valid).
- Latency: result handshaken in cycle c is broadcast no earlier than cycle c+2. There is no bypass.
- Throughput: one broadcast per cycle, sustained while any FIFO is non-empty.
- Fairness: with all FUs continuously non-empty, each FU is granted exactly once every NUM_FU cycles.
- Per-FU ordering: strict FIFO. No ordering is guaranteed across FUs.
- Wrap-around: FIFO pointers wrap modulo BUF_DEPTH; rr_ptr wraps modulo NUM_FU.
- A single FIFO has exactly one pop per cycle at most.

Optional Feature:
- Macro: CDB_FLUSH_EN.
- Defined: adds the flush_in port, used for branch mispredict recovery.
  - flush_in high at an edge empties every FIFO, forces cdb_valid_out<=0 and rr_ptr<=0.
  - Results presented in the same cycle as flush_in are dropped.
  - Flush takes priority over push and pop.
- Undefined: no flush_in port and no flush logic. Behaviour is otherwise identical.

Decomposition:
- Package cdb_pkg holds:
  - ROB_IX_W default constant;
  - cdb_entry_t packed struct {rob_ix, value, dest};
  - a helper function rr_next(ptr, NUM_FU).
- One natural sub-module, cdb_result_fifo: a BUF_DEPTH-deep cdb_entry_t FIFO with push, pop, full, empty, count and (under the macro) clear. It is instantiated NUM_FU times via generate.

Test Plan:
- Single result: FU1 sends {rob_ix=5, value=-7, dest=12} in cycle 3 → cdb_valid_out=1 with those values in cycle 5 only; valid=0 in cycle 6.
- Round-robin: FU0..FU3 each push one result in the same cycle with rob_ix 0,1,2,3, rr_ptr=0 → broadcasts in order 0,1,2,3 on consecutive cycles; rr_ptr ends at 0.
- Backpressure: FU2 pushes 3 results back-to-back while FU0 holds the grant, with BUF_DEPTH=2 → fu_ready_out[2]=0 after two accepts; the third is held, accepted after the first pop, and all three broadcast in order.
- Fairness: all FUs valid every cycle for 40 cycles → each FU granted exactly 10 times, and no FU waits more than 4 cycles between grants.
- Async reset mid-traffic: assert rst_in between edges with FIFOs non-empty → cdb_valid_out=0 immediately, with no stale broadcast after release.
- With CDB_FLUSH_EN: flush_in in the same cycle FU0 pushes rob_ix=4 and FIFOs hold 3 entries → next cycle cdb_valid_out=0, and rob_ix=4 is never broadcast.

Source files
------------

// File: rtl/cdb_pkg.sv
// -----------------------------------------------------------------------------
// cdb_pkg
// Shared types and helpers for the common-data-bus arbiter slice.
//   CDB_ROB_IX_W : default ROB index width (ROB of 8 entries)
//   cdb_entry_t  : one completed result {rob_ix, value, dest}
//   rr_next      : round-robin successor of a pointer modulo num_fu
// -----------------------------------------------------------------------------
package cdb_pkg;

    localparam int CDB_ROB_IX_W = 3;

    typedef struct packed {
        logic [CDB_ROB_IX_W-1:0] rob_ix;
        logic [31:0]             value;
        logic [31:0]             dest;
    } cdb_entry_t;

    // Next round-robin position, wrapping back to zero after num_fu-1.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned num_fu);
        int unsigned nxt_v;
        if (ptr + 32'd1 >= num_fu) begin
            nxt_v = 32'd0;
        end else begin
            nxt_v = ptr + 32'd1;
        end
        return nxt_v;
    endfunction

endpackage

// File: rtl/cdb_result_fifo.sv
// -----------------------------------------------------------------------------
// cdb_result_fifo
// DEPTH-entry FIFO of cdb_entry_t holding one functional unit's completed
// results until the arbiter grants them onto the CDB.
// Optional feature macro: CDB_FLUSH_EN adds the synchronous 'clear' input.
// Ports:
//   clk_in, rst_in : clock, asynchronous active-high reset
//   clear          : (CDB_FLUSH_EN only) empty the FIFO; wins over push/pop
//   push, wr_data  : write one entry (ignored while full)
//   pop            : drop the head entry (ignored while empty)
//   rd_data        : current head entry
//   full, empty    : occupancy flags, derived from the registered count
//   count          : registered number of valid entries
// -----------------------------------------------------------------------------
module cdb_result_fifo
    import cdb_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
`ifdef CDB_FLUSH_EN
    input  logic             clear,
`endif
    input  logic             push,
    input  cdb_entry_t       wr_data,
    input  logic             pop,
    output cdb_entry_t       rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    cdb_entry_t       mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Pointer increment wrapping at DEPTH (DEPTH need not be a power of two).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n_v;
        if (p == PTR_W'(DEPTH - 1)) begin
            n_v = {PTR_W{1'b0}};
        end else begin
            n_v = p + PTR_W'(1'b1);
        end
        return n_v;
    endfunction

    // Qualify requests against current occupancy so misuse cannot corrupt state.
    always_comb begin
        push_ok_s = push && (count_r != CNT_W'(DEPTH));
        pop_ok_s  = pop  && (count_r != {CNT_W{1'b0}});
    end

    // Storage write; data needs no reset because count gates visibility.
    always_ff @(posedge clk_in) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end
`ifdef CDB_FLUSH_EN
        else if (clear) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end
`endif
        else begin
            if (push_ok_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign full    = (count_r == CNT_W'(DEPTH));
    assign empty   = (count_r == {CNT_W{1'b0}});
    assign count   = count_r;

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Producer end of the common data bus. Each functional unit's results are
// buffered in its own FIFO; every cycle one non-empty FIFO head is chosen
// round-robin and broadcast through a register on the cdb_* outputs.
// Optional feature macro: CDB_FLUSH_EN adds flush_in (mispredict recovery),
// which empties all FIFOs, drops the broadcast and resets the rr pointer.
// Ports:
//   clk_in, rst_in  : clock, asynchronous active-high reset
//   flush_in        : (CDB_FLUSH_EN only) flush everything at the next edge
//   fu_valid_in     : per-FU result valid
//   fu_rob_ix_in    : packed ROB indices, FU i at slice i
//   fu_value_in     : packed 32-bit signed results
//   fu_dest_in      : packed 32-bit destination fields
//   fu_ready_out    : per-FU "buffer has room", from registered occupancy only
//   cdb_valid_out   : registered broadcast valid
//   cdb_rob_ix_out, cdb_value_out, cdb_dest_out : registered broadcast payload
// -----------------------------------------------------------------------------
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter  int NUM_FU    = 4,
    parameter  int BUF_DEPTH = 2,
    parameter  int ROB_IX_W  = CDB_ROB_IX_W,
    localparam int PTR_W     = $clog2(NUM_FU),
    localparam int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
`ifdef CDB_FLUSH_EN
    input  logic                       flush_in,
`endif
    input  logic [NUM_FU-1:0]          fu_valid_in,
    input  logic [NUM_FU*ROB_IX_W-1:0] fu_rob_ix_in,
    input  logic [NUM_FU*32-1:0]       fu_value_in,
    input  logic [NUM_FU*32-1:0]       fu_dest_in,
    output logic [NUM_FU-1:0]          fu_ready_out,
    output logic                       cdb_valid_out,
    output logic [ROB_IX_W-1:0]        cdb_rob_ix_out,
    output logic signed [31:0]         cdb_value_out,
    output logic [31:0]                cdb_dest_out
);

    cdb_entry_t        wr_entry_s [NUM_FU];
    cdb_entry_t        head_s     [NUM_FU];
    logic [CNT_W-1:0]  count_s    [NUM_FU];
    logic [NUM_FU-1:0] push_s;
    logic [NUM_FU-1:0] pop_s;
    logic [NUM_FU-1:0] full_s;
    logic [NUM_FU-1:0] empty_s;
    logic [PTR_W-1:0]  rr_ptr_r;
    logic [PTR_W-1:0]  winner_s;
    logic [PTR_W-1:0]  idx_s;
    logic              grant_s;
    cdb_entry_t        sel_s;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
        assign wr_entry_s[i] = {fu_rob_ix_in[i*ROB_IX_W +: ROB_IX_W],
                                fu_value_in[i*32 +: 32],
                                fu_dest_in[i*32 +: 32]};
        assign push_s[i]       = fu_valid_in[i] & ~full_s[i];
        // Ready comes from the registered count alone: a full FIFO stays
        // not-ready even in a cycle where it is being popped.
        assign fu_ready_out[i] = (count_s[i] != CNT_W'(BUF_DEPTH));
        assign pop_s[i]        = grant_s && (winner_s == PTR_W'(i));

        cdb_result_fifo #(
            .DEPTH (BUF_DEPTH)
        ) u_fifo (
            .clk_in  (clk_in),
            .rst_in  (rst_in),
`ifdef CDB_FLUSH_EN
            .clear   (flush_in),
`endif
            .push    (push_s[i]),
            .wr_data (wr_entry_s[i]),
            .pop     (pop_s[i]),
            .rd_data (head_s[i]),
            .full    (full_s[i]),
            .empty   (empty_s[i]),
            .count   (count_s[i])
        );
    end

    // Round-robin pick: first non-empty FIFO at or after rr_ptr_r, wrapping.
    always_comb begin
        grant_s  = 1'b0;
        winner_s = rr_ptr_r;
        idx_s    = rr_ptr_r;
        for (int k = 0; k < NUM_FU; k++) begin
            if (!grant_s && !empty_s[idx_s]) begin
                grant_s  = 1'b1;
                winner_s = idx_s;
            end else begin
                grant_s  = grant_s;
            end
            idx_s = PTR_W'(rr_next(32'(idx_s), NUM_FU));
        end
        sel_s = head_s[winner_s];
    end

    // Broadcast register and rr pointer; payload holds when nothing is granted.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cdb_valid_out  <= 1'b0;
            cdb_rob_ix_out <= {ROB_IX_W{1'b0}};
            cdb_value_out  <= 32'sd0;
            cdb_dest_out   <= 32'd0;
            rr_ptr_r       <= {PTR_W{1'b0}};
        end
`ifdef CDB_FLUSH_EN
        else if (flush_in) begin
            cdb_valid_out <= 1'b0;
            rr_ptr_r      <= {PTR_W{1'b0}};
        end
`endif
        else if (grant_s) begin
            cdb_valid_out  <= 1'b1;
            cdb_rob_ix_out <= sel_s.rob_ix;
            cdb_value_out  <= sel_s.value;
            cdb_dest_out   <= sel_s.dest;
            rr_ptr_r       <= PTR_W'(rr_next(32'(winner_s), NUM_FU));
        end else begin
            cdb_valid_out  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
`timescale 1ns/1ps
module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int D  = 2;
    localparam int RW = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    fu_valid = '0;
    logic [N*RW-1:0] fu_rob = '0;
    logic [N*32-1:0] fu_val = '0;
    logic [N*32-1:0] fu_dst = '0;
    logic [N-1:0]    fu_ready;
    logic            cdb_valid;
    logic [RW-1:0]   cdb_rob;
    logic [31:0]     cdb_val;
    logic [31:0]     cdb_dst;
`ifdef CDB_FLUSH_EN
    logic            flush = 1'b0;
`endif

    cdb_arbiter #(.NUM_FU(N), .BUF_DEPTH(D), .ROB_IX_W(RW)) dut (
        .clk_in         (clk),
        .rst_in         (rst),
`ifdef CDB_FLUSH_EN
        .flush_in       (flush),
`endif
        .fu_valid_in    (fu_valid),
        .fu_rob_ix_in   (fu_rob),
        .fu_value_in    (fu_val),
        .fu_dest_in     (fu_dst),
        .fu_ready_out   (fu_ready),
        .cdb_valid_out  (cdb_valid),
        .cdb_rob_ix_out (cdb_rob),
        .cdb_value_out  (cdb_val),
        .cdb_dest_out   (cdb_dst)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: one queue per FU, a round-robin start index, and the
    // broadcast expected to be visible after the next edge.
    logic [66:0] q [N][$];
    int          rr;
    logic        exp_valid;
    logic [66:0] exp_ent;
    logic [N-1:0] pend_v;
    logic [66:0] pend [N];

    task automatic check(input string tag, input logic [66:0] got, input logic [66:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, want);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) q[i].delete();
        rr = 0;
        exp_valid = 1'b0;
        exp_ent = '0;
        pend_v = '0;
    endtask

    task automatic set_pend(input int i, input logic [2:0] rob, input logic [31:0] v, input logic [31:0] d);
        pend[i] = {rob, v, d};
        pend_v[i] = 1'b1;
    endtask

    task automatic check_outputs();
        logic [N-1:0] rdy;
        for (int i = 0; i < N; i++) rdy[i] = (q[i].size() < D);
        check("cdb_valid", 67'(cdb_valid), 67'(exp_valid));
        check("cdb_entry", {cdb_rob, cdb_val, cdb_dst}, exp_ent);
        check("fu_ready", 67'(fu_ready), 67'(rdy));
    endtask

    task automatic drive();
        fu_valid = pend_v;
        for (int i = 0; i < N; i++) begin
            fu_rob[i*RW +: RW] = pend[i][66:64];
            fu_val[i*32 +: 32] = pend[i][63:32];
            fu_dst[i*32 +: 32] = pend[i][31:0];
        end
    endtask

    // Apply the arbiter's rules for the upcoming edge, then wait a cycle.
    task automatic step(input bit fl);
        logic [N-1:0] acc;
        int w;
        for (int i = 0; i < N; i++) acc[i] = pend_v[i] && (q[i].size() < D);
        if (fl) begin
            for (int i = 0; i < N; i++) q[i].delete();
            exp_valid = 1'b0;
            rr = 0;
            pend_v = '0;
        end else begin
            exp_valid = 1'b0;
            for (int k = 0; k < N; k++) begin
                w = (rr + k) % N;
                if (!exp_valid && q[w].size() > 0) begin
                    exp_ent = q[w].pop_front();
                    exp_valid = 1'b1;
                    rr = (w + 1) % N;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    q[i].push_back(pend[i]);
                    pend_v[i] = 1'b0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic cycle(input bit fl);
        check_outputs();
        drive();
`ifdef CDB_FLUSH_EN
        flush = fl;
`endif
        step(fl);
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_valid", 67'(cdb_valid), 67'd0);
        check("rst_entry", {cdb_rob, cdb_val, cdb_dst}, 67'd0);
        fu_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic rand_traffic(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            for (int i = 0; i < N; i++)
                if (!pend_v[i] && $urandom_range(0, 1) == 1)
                    set_pend(i, 3'($urandom_range(0, 7)), $urandom, $urandom);
            cycle(1'b0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int grants [N];
        int last [N];
        int maxgap;
        int bp_sent;
        logic [31:0] bp_got [$];

        model_reset();
        @(negedge clk);
        check("init_valid", 67'(cdb_valid), 67'd0);
        check("init_entry", {cdb_rob, cdb_val, cdb_dst}, 67'd0);
        @(negedge clk);
        rst = 1'b0;

        // Round robin from rr_ptr=0: all four FUs push together.
        for (int i = 0; i < N; i++) set_pend(i, 3'(i), 32'(1000 + i), 32'(i));
        cycle(1'b0);
        cycle(1'b0);
        for (int k = 0; k < N; k++) begin
            check("rr_valid", 67'(cdb_valid), 67'd1);
            check("rr_order", 67'(cdb_rob), 67'(k));
            cycle(1'b0);
        end
        cycle(1'b0);

        // Single result: visible two cycles after the handshake, for one cycle.
        set_pend(1, 3'd5, 32'hFFFF_FFF9, 32'd12);
        cycle(1'b0);
        check("single_early", 67'(cdb_valid), 67'd0);
        cycle(1'b0);
        check("single_valid", 67'(cdb_valid), 67'd1);
        check("single_data", {cdb_rob, cdb_val, cdb_dst}, {3'd5, 32'hFFFF_FFF9, 32'd12});
        cycle(1'b0);
        check("single_after", 67'(cdb_valid), 67'd0);
        cycle(1'b0);

        // Backpressure: FU2 sends three back-to-back while FU0 competes.
        pulse_reset();
        bp_sent = 0;
        for (int c = 0; c < 14; c++) begin
            if (c < 6 && !pend_v[0]) set_pend(0, 3'd0, 32'(c), 32'd0);
            if (bp_sent < 3 && !pend_v[2]) begin
                set_pend(2, 3'(bp_sent + 1), 32'(100 + bp_sent), 32'd2);
                bp_sent++;
            end
            if (c == 2) check("bp_ready2_low", 67'(fu_ready[2]), 67'd0);
            if (cdb_valid && cdb_dst == 32'd2) bp_got.push_back(cdb_val);
            cycle(1'b0);
        end
        check("bp_count", 67'(bp_got.size()), 67'd3);
        for (int k = 0; k < 3; k++)
            if (k < bp_got.size()) check("bp_order", 67'(bp_got[k]), 67'(100 + k));

        // Fairness: every FU always valid; measure a 40-cycle window.
        for (int i = 0; i < N; i++) begin grants[i] = 0; last[i] = -1; end
        maxgap = 0;
        for (int c = 0; c < 48; c++) begin
            for (int i = 0; i < N; i++)
                if (!pend_v[i]) set_pend(i, 3'(i), $urandom, 32'(i));
            if (c >= 8 && cdb_valid) begin
                grants[cdb_dst[1:0]]++;
                if (last[cdb_dst[1:0]] >= 0 && c - last[cdb_dst[1:0]] > maxgap)
                    maxgap = c - last[cdb_dst[1:0]];
                last[cdb_dst[1:0]] = c;
            end
            cycle(1'b0);
        end
        for (int i = 0; i < N; i++) check("fair_count", 67'(grants[i]), 67'd10);
        check("fair_gap_le4", 67'(maxgap <= 4), 67'd1);

        rand_traffic(300);

        // Asynchronous reset with traffic in flight.
        for (int i = 0; i < N; i++)
            if (!pend_v[i]) set_pend(i, 3'($urandom_range(0, 7)), $urandom, $urandom);
        cycle(1'b0);
        cycle(1'b0);
        pulse_reset();
        for (int c = 0; c < 4; c++) cycle(1'b0);
        rand_traffic(100);

`ifdef CDB_FLUSH_EN
        pulse_reset();
        set_pend(1, 3'd1, 32'd11, 32'd1);
        set_pend(2, 3'd2, 32'd22, 32'd2);
        set_pend(3, 3'd3, 32'd33, 32'd3);
        cycle(1'b0);
        set_pend(0, 3'd4, 32'd44, 32'd0);
        cycle(1'b1);
        check("flush_valid", 67'(cdb_valid), 67'd0);
        for (int c = 0; c < 6; c++) begin
            check("flush_drop", 67'(cdb_valid && cdb_rob == 3'd4), 67'd0);
            cycle(1'b0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
